// File: rtl/mul_pipe_param.sv
// Pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU) with per-slot valid/ready,
// bubble-collapsing advance chain and a synchronous flush.

module mul_pipe_slot #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [XLEN-1:0]  prev_result,
    input  logic [TAG_W-1:0] prev_tag,
    output logic             valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            result <= '0;
            tag    <= '0;
        end else begin
            if (flush)    valid <= 1'b0;
            else if (adv) valid <= prev_valid;
            // Data only moves with a real op so a stalled output stays stable.
            if (adv && prev_valid) begin
                result <= prev_result;
                tag    <= prev_tag;
            end
        end
    end
endmodule

module mul_pipe_param #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // Index 0 is the input side; index i+1 is slot i.
    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][XLEN-1:0]   res_pipe;
    logic [STAGES:0][TAG_W-1:0]  tag_pipe;
    logic [STAGES-1:0]           adv;

    logic              sgn_a, sgn_b;
    logic [2*XLEN-1:0] a_w, b_w, prod;

    // Extending to 2*XLEN and multiplying mod 2^(2*XLEN) yields the same low 2*XLEN bits
    // as the (XLEN+1)-bit signed product.
    assign sgn_a = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    assign sgn_b = (in_op == OP_MULH);
    assign a_w   = {{XLEN{sgn_a & in_a[XLEN-1]}}, in_a};
    assign b_w   = {{XLEN{sgn_b & in_b[XLEN-1]}}, in_b};
    assign prod  = a_w * b_w;

    assign vld_pipe[0] = in_valid;
    assign res_pipe[0] = (in_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign tag_pipe[0] = in_tag;

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_slot
            // Slot i may advance if the output drains or any slot from i onward is empty.
            assign adv[i] = out_ready || !(&vld_pipe[STAGES:i+1]);

            mul_pipe_slot #(.XLEN(XLEN), .TAG_W(TAG_W)) u_slot (
                .clk         (clk),
                .rst         (rst),
                .flush       (flush),
                .adv         (adv[i]),
                .prev_valid  (vld_pipe[i]),
                .prev_result (res_pipe[i]),
                .prev_tag    (tag_pipe[i]),
                .valid       (vld_pipe[i+1]),
                .result      (res_pipe[i+1]),
                .tag         (tag_pipe[i+1])
            );
        end
    endgenerate

    assign in_ready   = adv[0];
    assign out_valid  = vld_pipe[STAGES];
    assign out_result = res_pipe[STAGES];
    assign out_tag    = tag_pipe[STAGES];
    assign busy       = |vld_pipe[STAGES:1];
endmodule

// File: tb/tb_mul_pipe_param.sv
// Directed bench for mul_pipe_param (XLEN=32, STAGES=3): op table, streaming,
// backpressure, bubble collapse, flush and async reset.

module tb_mul_pipe_param;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b, out_result;
    logic [4:0]  in_tag, out_tag;

    int checks   = 0;
    int failures = 0;

    mul_pipe_param #(.XLEN(32), .STAGES(3), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    // Waits for out_valid after an accept edge; returns number of edges including the accept edge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, got, first, drops;
        logic [63:0] full;
        logic [31:0] sexp[10];

        vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB};
        vecs[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000};
        vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE};
        vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF};
        vecs[4] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000};
        vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF};
        vecs[6] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 5'd7,  32'h0000_0001};
        vecs[7] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 5'd8,  32'h2345_6780};
        vecs[8] = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 5'd9,  32'h0000_0001};
        vecs[9] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'hC000_0000};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out_result", 64'(out_result), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b1;
        #1 chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Op table, one at a time, unstalled.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            chk("op_in_ready", 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            wait_out(lat);
            chk("op_latency", 64'(lat), 64'd3);
            chk("op_result", 64'(out_result), 64'(vecs[i].exp));
            chk("op_tag", 64'(out_tag), 64'(vecs[i].tag));
            tick();
            chk("op_drain_busy", 64'(busy), 64'd0);
        end

        // Back-to-back stream of 10 ops, alternating MUL / MULHU.
        got = 0; first = -1; drops = 0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid) begin
                if (got >= 10) chk("stream_extra", 64'd1, 64'd0);
                else begin
                    if (first < 0) first = t;
                    chk("stream_result", 64'(out_result), 64'(sexp[got]));
                    chk("stream_tag", 64'(out_tag), 64'(got));
                    chk("stream_gap", 64'(t), 64'(first + got));
                    got++;
                end
            end
            if (t < 10) begin
                logic [31:0] a, b;
                a = 32'h0101_0101 * t + 32'h1234_5007;
                b = 32'h0300_0000 + t;
                full = {32'b0, a} * {32'b0, b};
                sexp[t] = (t % 2 == 0) ? full[31:0] : full[63:32];
                drive((t % 2 == 0) ? 2'b00 : 2'b11, a, b, 5'(t));
                if (!in_ready) drops++;
            end else in_valid = 1'b0;
            tick();
        end
        chk("stream_count", 64'(got), 64'd10);
        chk("stream_first", 64'(first), 64'd3);
        chk("stream_ready_drops", 64'(drops), 64'd0);

        // Fill with 3 ops under output stall.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(2'b00, 32'(k + 2), 32'(k + 10), 5'(10 + k));
            chk("fill_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_result", 64'(out_result), 64'd20);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_result", 64'(out_result), 64'd20);
            chk("stall_tag", 64'(out_tag), 64'd10);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        chk("release_0", 64'(out_result), 64'd20);
        tick();
        chk("release_1", 64'(out_result), 64'd33);
        chk("release_1_valid", 64'(out_valid), 64'd1);
        tick();
        chk("release_2", 64'(out_result), 64'd48);
        chk("release_2_valid", 64'(out_valid), 64'd1);
        tick();
        chk("release_empty", 64'(out_valid), 64'd0);

        // Bubble collapse: one op reaches the tail, then stall and add two more.
        drive(2'b11, 32'h8000_0000, 32'h0000_0004, 5'd20);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("bubble_a_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        drive(2'b00, 32'd6, 32'd7, 5'd21);
        chk("bubble_b_ready", 64'(in_ready), 64'd1);
        tick();
        drive(2'b00, 32'd9, 32'd9, 5'd22);
        chk("bubble_c_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bubble_full_ready", 64'(in_ready), 64'd0);
        chk("bubble_busy", 64'(busy), 64'd1);
        chk("bubble_a_result", 64'(out_result), 64'd2);
        out_ready = 1'b1;
        tick();
        chk("bubble_b_result", 64'(out_result), 64'd42);
        chk("bubble_b_tag", 64'(out_tag), 64'd21);
        tick();
        chk("bubble_c_result", 64'(out_result), 64'd81);
        tick();
        chk("bubble_empty", 64'(out_valid), 64'd0);

        // Flush with two in flight and a new op offered the same cycle.
        drive(2'b00, 32'd3, 32'd5, 5'd1);
        tick();
        drive(2'b00, 32'd4, 32'd5, 5'd2);
        tick();
        drive(2'b00, 32'd8, 32'd5, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid_0", 64'(out_valid), 64'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("flush_valid_n", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            drive(2'b00, 32'(k + 2), 32'd3, 5'(k + 1));
            tick();
        end
        in_valid = 1'b0;
        chk("prereset_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_out_result", 64'(out_result), 64'd0);
        chk("async_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_reset_idle", 64'(out_valid), 64'd0);
        end
        drive(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd7);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        chk("post_reset_latency", 64'(lat), 64'd3);
        chk("post_reset_result", 64'(out_result), 64'hFFFF_FFFF);
        chk("post_reset_tag", 64'(out_tag), 64'd7);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
